adc_spi_reader: RTL
===================

# adc_spi_reader

SPI front end for the external 12-bit serial ADC; sits directly upstream of `data_acquire`.
- Each rising edge of `adc_data_req_i` runs one chip-select frame on the ADC bus and shifts in one sample.
- It then presents the sample on `adc_data_o` with level-type `adc_data_rdy_o`, matching the request/ready handshake `data_acquire` expects.
- An optional offset-binary to two's-complement conversion gives `data_acquire` signed samples directly.

## Interface
Parameters:
- `CLK_DIV`, 2: `clk_i` cycles per SCLK half-period; ≥1.
- `FRAME_BITS`, 16: SCLK periods per frame.
- `LEAD_BITS`, 4: bits before the data MSB in a frame.
  - `LEAD_BITS + DATA_W ≤ FRAME_BITS` is checked at elaboration.
- `DATA_W`, 12: sample width.
- `OFFSET_BIN`, 0: when 1, the data MSB is inverted to convert offset binary to two's complement.
- `QUIET_CYC`, 4: minimum `cs_n_o`-high cycles between frames.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `reset_n_i`  in  1  reset, synchronous, active-low.
- `adc_data_req_i`  in  1  conversion request; acts on its rising edge.
- `adc_data_rdy_o`  out  1  high when `adc_data_o` holds a completed sample; low while a frame is in progress.
- `adc_data_o`  out  `DATA_W`  last sample.
- `cs_n_o`  out  1  ADC chip select, active-low.
- `sclk_o`  out  1  ADC serial clock; idles high.
- `miso_i`  in  1  ADC serial data, MSB first; sampled directly by `clk_i`, with no synchronizer.

## Operation
- **Reset values:**
  - `cs_n_o=1`, `sclk_o=1`, `adc_data_rdy_o=0`, `adc_data_o=0`.
  - `state=IDLE`; pending flag, bit counter and divider counter all 0.
- **Edge detect:** `req_d` registers `adc_data_req_i`. `req_edge = adc_data_req_i & ~req_d`.
- **States:**
  - IDLE → SETUP on `req_edge` or pending. This clears pending and drives `cs_n_o=0` and `adc_data_rdy_o=0`.
  - SETUP: holds `cs_n_o` low for `CLK_DIV` cycles, then → SHIFT.
  - SHIFT: `FRAME_BITS` SCLK periods, each consisting of:
    - low for `CLK_DIV` cycles;
    - high for `CLK_DIV` cycles.

    `miso_i` is shifted into a `FRAME_BITS` register on the cycle `sclk_o` goes 0→1. After the last bit's high phase completes → QUIET.
  - QUIET entry, all in the same cycle:
    - `cs_n_o=1`;
    - `adc_data_o = shift[FRAME_BITS-LEAD_BITS-1 -: DATA_W]`, with the MSB inverted if `OFFSET_BIN`;
    - `adc_data_rdy_o=1`.

    QUIET holds for `QUIET_CYC` cycles, then → IDLE.
- **`adc_data_rdy_o` and `adc_data_o`:** `adc_data_rdy_o` stays high until the next frame starts. `adc_data_o` holds its value until the next QUIET entry.
- **Request while busy:** a `req_edge` in SETUP/SHIFT/QUIET sets pending; more edges do not queue further. The pending frame starts on the cycle IDLE is entered.
- **Reset mid-frame:** returns to reset values at the next edge. The frame is aborted and `cs_n_o` rises immediately.

## Timing
- `req_edge` detected at cycle E:
  - `cs_n_o` falls and `adc_data_rdy_o` falls at E+1.
  - First SCLK falling edge at E+`CLK_DIV`+1.
  - `adc_data_rdy_o` rises at E+1+`CLK_DIV`+2·`FRAME_BITS`·`CLK_DIV`; with defaults this is E+67.
- Minimum request-to-request period: 67+`QUIET_CYC` = 71 cycles with defaults.
- `sclk_o` and `cs_n_o` are register outputs, glitch-free.

## Structure
- Package `adc_spi_pkg` holds:
  - the state enum (IDLE, SETUP, SHIFT, QUIET);
  - the default parameter constants;
  - a width function `$clog2(FRAME_BITS+1)` for the bit counter.
- Sub-module `adc_spi_sclk_gen` is the divider counter. It produces `sclk_o`, a `rise` strobe and a `period_done` strobe, and is enabled only in SHIFT.
- The FSM, shift register and output register stay in the top module.

## Test plan
- ADC model drives frame 0x0ABC with defaults, req rises at cycle E:
  - `cs_n_o` low from E+1;
  - 16 SCLK pulses of 4 cycles each;
  - `adc_data_rdy_o` rises at E+67;
  - `adc_data_o` = 0xABC.
- Same frame with `OFFSET_BIN=1` → `adc_data_o` = 0x2BC; frame 0x0800 → 0x000.
- Req edge at E+20 during an active frame → first frame completes unchanged. The second frame's `cs_n_o` falls at E+67+`QUIET_CYC`+1; a third edge in the same window is dropped.
- `reset_n_i` low at E+30 for 1 cycle:
  - next cycle `cs_n_o=1`, `sclk_o=1`, rdy=0, data=0;
  - a new req completes normally.
- Connected to `data_acquire` with ADC frames 1..8 on `syncro_i` → `data_o` = 4 (sum 36 >>> 3) with `data_rdy_o` pulse.
- With ADC values (0xFFF × 8) → `data_o` = −1 (0xFFF).

Source files
------------

// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg -- shared definitions for the adc_spi_reader slice.
//   * default parameter values of the reader
//   * FSM state encoding (IDLE, SETUP, SHIFT, QUIET)
//   * counter width helpers
package adc_spi_pkg;

  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_LEAD_BITS  = 4;
  localparam int DEF_DATA_W     = 12;
  localparam int DEF_OFFSET_BIN = 0;
  localparam int DEF_QUIET_CYC  = 4;

  // Legacy-compatible 2-bit state encoding.
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SETUP = 2'd1;
  localparam state_t SHIFT = 2'd2;
  localparam state_t QUIET = 2'd3;

  // Width of the per-frame bit counter (holds 0..FRAME_BITS).
  function automatic int bit_cnt_w(input int frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

  // Width of a counter that runs 0..max_val-1 (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/adc_spi_reader_if.sv
// adc_spi_reader_if -- request/ready handshake towards data_acquire plus the
// ADC SPI pins.
//   adc_data_req_i  conversion request (rising edge starts a frame)
//   adc_data_rdy_o  sample valid level
//   adc_data_o      last sample, DATA_W bits
//   cs_n_o          ADC chip select, active-low
//   sclk_o          ADC serial clock, idles high
//   miso_i          ADC serial data, MSB first
// Modports: slave = the reader, master = requester / ADC side.
interface adc_spi_reader_if
  import adc_spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              adc_data_req_i;
  logic              adc_data_rdy_o;
  logic [DATA_W-1:0] adc_data_o;
  logic              cs_n_o;
  logic              sclk_o;
  logic              miso_i;

  modport slave (
    input  adc_data_req_i,
    input  miso_i,
    output adc_data_rdy_o,
    output adc_data_o,
    output cs_n_o,
    output sclk_o
  );

  modport master (
    output adc_data_req_i,
    output miso_i,
    input  adc_data_rdy_o,
    input  adc_data_o,
    input  cs_n_o,
    input  sclk_o
  );

endinterface

// File: rtl/adc_spi_sclk_gen.sv
// adc_spi_sclk_gen -- SCLK divider for adc_spi_reader.
//   clk_i        system clock
//   reset_n_i    synchronous active-low reset
//   start        pulse: begin the first SCLK low phase on the next edge
//   en           high while the reader is shifting
//   last         current period is the final one of the frame
//   sclk_o       registered serial clock, idles high
//   rise         strobe on the cycle sclk_o goes 0->1
//   period_done  strobe on the cycle a high phase completes
module adc_spi_sclk_gen
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic start,
  input  logic en,
  input  logic last,
  output logic sclk_o,
  output logic rise,
  output logic period_done
);

  localparam int DW = cnt_w(CLK_DIV);

  logic [DW-1:0] div_cnt;
  logic          phase_end;

  assign phase_end   = en && (div_cnt == DW'(CLK_DIV - 1));
  assign rise        = phase_end && !sclk_o;
  assign period_done = phase_end && sclk_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      div_cnt <= '0;
      sclk_o  <= 1'b1;
    end else if (start) begin
      // SCLK falls on the same edge the reader enters SHIFT.
      div_cnt <= '0;
      sclk_o  <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk_o  <= 1'b1;
    end else if (phase_end) begin
      div_cnt <= '0;
      // After the final high phase SCLK stays high (idle) instead of falling.
      sclk_o  <= ~sclk_o | last;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// adc_spi_reader -- SPI front end for the external serial ADC.
// Each rising edge of adc_data_req_i runs one chip-select frame, shifts in
// FRAME_BITS bits and presents the DATA_W-bit sample field on adc_data_o with
// a level-type adc_data_rdy_o. Optional offset-binary to two's-complement
// conversion by inverting the sample MSB.
//   clk_i      system clock, the only clock
//   reset_n_i  synchronous active-low reset
//   bus        adc_spi_reader_if.slave: request/ready/data + SPI pins
module adc_spi_reader
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int LEAD_BITS  = DEF_LEAD_BITS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int OFFSET_BIN = DEF_OFFSET_BIN,
  parameter int QUIET_CYC  = DEF_QUIET_CYC
) (
  input logic             clk_i,
  input logic             reset_n_i,
  adc_spi_reader_if.slave bus
);

  if (LEAD_BITS + DATA_W > FRAME_BITS) begin : g_bad_layout
    $error("adc_spi_reader: LEAD_BITS + DATA_W exceeds FRAME_BITS");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("adc_spi_reader: CLK_DIV must be at least 1");
  end
  if (FRAME_BITS < 2) begin : g_bad_frame
    $error("adc_spi_reader: FRAME_BITS must be at least 2");
  end
  if (QUIET_CYC < 1) begin : g_bad_quiet
    $error("adc_spi_reader: QUIET_CYC must be at least 1");
  end

  localparam int BCW = bit_cnt_w(FRAME_BITS);
  localparam int CCW = cnt_w((CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC);

  state_t                state;
  logic                  req_d;
  logic                  req_edge;
  logic                  pending;
  logic [BCW-1:0]        bit_cnt;
  logic [CCW-1:0]        cyc_cnt;
  logic [FRAME_BITS-1:0] shift_q;
  logic                  cs_n_q;
  logic                  rdy_q;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W-1:0]     sample;

  logic setup_done;
  logic last_bit;
  logic sclk;
  logic sclk_rise;
  logic sclk_period_done;

  assign req_edge   = bus.adc_data_req_i & ~req_d;
  assign setup_done = (state == SETUP) && (cyc_cnt == CCW'(CLK_DIV - 1));
  assign last_bit   = (bit_cnt == BCW'(FRAME_BITS - 1));

  adc_spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .start       (setup_done),
    .en          (state == SHIFT),
    .last        (last_bit),
    .sclk_o      (sclk),
    .rise        (sclk_rise),
    .period_done (sclk_period_done)
  );

  // Sample field of the completed frame, optionally converted to signed.
  always_comb begin
    sample = shift_q[FRAME_BITS-LEAD_BITS-1 -: DATA_W];
    if (OFFSET_BIN != 0) begin
      sample[DATA_W-1] = ~sample[DATA_W-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      req_d   <= 1'b0;
      pending <= 1'b0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      shift_q <= '0;
      cs_n_q  <= 1'b1;
      rdy_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      req_d <= bus.adc_data_req_i;

      // A request while busy is remembered once; further edges are dropped.
      if (req_edge && (state != IDLE)) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (req_edge || pending) begin
            state   <= SETUP;
            pending <= 1'b0;
            cs_n_q  <= 1'b0;
            rdy_q   <= 1'b0;
            cyc_cnt <= '0;
          end
        end

        SETUP: begin
          if (setup_done) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            cyc_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (sclk_rise) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], bus.miso_i};
          end
          if (sclk_period_done) begin
            if (last_bit) begin
              state   <= QUIET;
              cs_n_q  <= 1'b1;
              data_q  <= sample;
              rdy_q   <= 1'b1;
              cyc_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        QUIET: begin
          if (cyc_cnt == CCW'(QUIET_CYC - 1)) begin
            state <= IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cs_n_o         = cs_n_q;
  assign bus.sclk_o         = sclk;
  assign bus.adc_data_rdy_o = rdy_q;
  assign bus.adc_data_o     = data_q;

endmodule
